// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-side controller for the 2R/1W register file.
//   Queues write-back requests in order, issues at most one PORT_C write per cycle
//   and (with RF_WB_BYPASS_EN defined) forwards pending/in-flight write data onto
//   the registered read results of ports A and B.
// Latency: accept at end of cycle n -> PORT_C_WE in cycle n+2 (empty queue, no hold).
// Backpressure: WB_READY drops when the queue holds DEPTH entries or RST is high;
//   WR_HOLD stalls issue without dropping requests.
// Ports:
//   CLK/RST            clock, synchronous active-high reset
//   WB_*               write-back request (valid/ready, address, data)
//   WR_HOLD            stall issue to PORT_C
//   PORT_C_*           register file write port
//   RD_x_ADDRESS       read addresses presented to the register file this cycle
//   RAM_x_OUT          register file read data (one cycle after the address)
//   OPERAND_x          read data corrected for pending writes
//   FWD_x_HIT          OPERAND_x came from the forwarding path
//   WB_EMPTY           nothing queued and nothing in flight
// Optional: define RF_WB_BYPASS_EN to build the forwarding comparators.
module regfile_wb_ctrl #(
  parameter int WIDTH  = 3,
  parameter int AWIDTH = 2,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WB_VALID,
  output logic              WB_READY,
  input  logic [AWIDTH-1:0] WB_ADDRESS,
  input  logic [WIDTH-1:0]  WB_DATA,
  input  logic              WR_HOLD,
  output logic [AWIDTH-1:0] PORT_C_ADDRESS,
  output logic [WIDTH-1:0]  PORT_C_DATA,
  output logic              PORT_C_WE,
  input  logic [AWIDTH-1:0] RD_A_ADDRESS,
  input  logic [AWIDTH-1:0] RD_B_ADDRESS,
  input  logic [WIDTH-1:0]  RAM_A_OUT,
  input  logic [WIDTH-1:0]  RAM_B_OUT,
  output logic [WIDTH-1:0]  OPERAND_A,
  output logic [WIDTH-1:0]  OPERAND_B,
  output logic              FWD_A_HIT,
  output logic              FWD_B_HIT,
  output logic              WB_EMPTY
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AWIDTH-1:0] q_addr [DEPTH];
  logic [WIDTH-1:0]  q_data [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;

  logic push;
  logic pop;

  // Ready looks at occupancy only; a pop in the same cycle does not open a slot.
  assign WB_READY = !RST && (count != FULL);
  assign push     = WB_VALID && WB_READY;
  assign pop      = (count != '0) && !WR_HOLD;
  assign WB_EMPTY = (count == '0) && !PORT_C_WE;

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_addr[wr_ptr] <= WB_ADDRESS;
      q_data[wr_ptr] <= WB_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      PORT_C_WE      <= 1'b0;
      PORT_C_ADDRESS <= '0;
      PORT_C_DATA    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      PORT_C_WE <= pop;
      if (pop) begin
        PORT_C_ADDRESS <= q_addr[rd_ptr];
        PORT_C_DATA    <= q_data[rd_ptr];
      end
    end
  end

`ifdef RF_WB_BYPASS_EN
  logic             hit_a_d, hit_b_d;
  logic [WIDTH-1:0] dat_a_d, dat_b_d;
  logic             hit_a_q, hit_b_q;
  logic [WIDTH-1:0] dat_a_q, dat_b_q;
  logic [PW-1:0]    idx;

  // Sources are applied lowest priority first so later matches override:
  // in-flight PORT_C write, then queue entries oldest to youngest, then the
  // request being accepted this cycle.
  always_comb begin
    hit_a_d = 1'b0;
    hit_b_d = 1'b0;
    dat_a_d = '0;
    dat_b_d = '0;
    idx     = '0;
    if (PORT_C_WE && (PORT_C_ADDRESS == RD_A_ADDRESS)) begin
      hit_a_d = 1'b1;
      dat_a_d = PORT_C_DATA;
    end
    if (PORT_C_WE && (PORT_C_ADDRESS == RD_B_ADDRESS)) begin
      hit_b_d = 1'b1;
      dat_b_d = PORT_C_DATA;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (q_addr[idx] == RD_A_ADDRESS)) begin
        hit_a_d = 1'b1;
        dat_a_d = q_data[idx];
      end
      if (((PW+1)'(i) < count) && (q_addr[idx] == RD_B_ADDRESS)) begin
        hit_b_d = 1'b1;
        dat_b_d = q_data[idx];
      end
    end
    if (push && (WB_ADDRESS == RD_A_ADDRESS)) begin
      hit_a_d = 1'b1;
      dat_a_d = WB_DATA;
    end
    if (push && (WB_ADDRESS == RD_B_ADDRESS)) begin
      hit_b_d = 1'b1;
      dat_b_d = WB_DATA;
    end
  end

  // Select registered alongside the register file's own read register so the
  // output mux lines up with RAM_x_OUT in the following cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_a_q <= 1'b0;
      hit_b_q <= 1'b0;
      dat_a_q <= '0;
      dat_b_q <= '0;
    end else begin
      hit_a_q <= hit_a_d;
      hit_b_q <= hit_b_d;
      dat_a_q <= dat_a_d;
      dat_b_q <= dat_b_d;
    end
  end

  assign OPERAND_A = hit_a_q ? dat_a_q : RAM_A_OUT;
  assign OPERAND_B = hit_b_q ? dat_b_q : RAM_B_OUT;
  assign FWD_A_HIT = hit_a_q;
  assign FWD_B_HIT = hit_b_q;
`else
  // Without forwarding the read addresses are not needed here.
  logic unused_rd_addr;
  assign unused_rd_addr = ^{RD_A_ADDRESS, RD_B_ADDRESS};

  assign OPERAND_A = RAM_A_OUT;
  assign OPERAND_B = RAM_B_OUT;
  assign FWD_A_HIT = 1'b0;
  assign FWD_B_HIT = 1'b0;
`endif

endmodule
